// File: rtl/aes_sched_pkg.sv
// Shared types and defaults for the AES cipher-core scheduler.
package aes_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } sched_state_t;

    localparam int TIMEOUT_DEFAULT = 32;
    localparam int BLOCK_W         = 128;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: the first valid request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    int off;
    int best;

    // Each requester's distance from ptr, walking upward with wrap; smallest distance wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        best  = NUM_REQ;
        off   = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            off = j + NUM_REQ - int'(ptr);
            if (off >= NUM_REQ) begin
                off = off - NUM_REQ;
            end
            if (req[j] && (off < best)) begin
                best  = off;
                idx   = ID_W'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = found && (idx == ID_W'(j));
        end
    end

endmodule

// File: rtl/aes_cipher_sched.sv
// Round-robin scheduler sharing one AES cipher core between NUM_REQ requesters.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
module aes_cipher_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_key,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_text,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [BLOCK_W-1:0]         resp_text,
    output logic [ID_W-1:0]            resp_id,
    output logic                       resp_err,
    output logic                       aes_ld,
    output logic [BLOCK_W-1:0]         aes_key,
    output logic [BLOCK_W-1:0]         aes_text_in,
    input  logic                       aes_done,
    input  logic [BLOCK_W-1:0]         aes_text_out,
    output logic                       busy,
    output sched_state_t               state
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic               win_found;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [BLOCK_W-1:0] sel_key;
    logic [BLOCK_W-1:0] sel_text;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        sel_key  = '0;
        sel_text = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_idx == ID_W'(j)) begin
                sel_key  = req_key[BLOCK_W*j +: BLOCK_W];
                sel_text = req_text[BLOCK_W*j +: BLOCK_W];
            end
        end
    end

    // Gated by rst so no grant is visible while reset is held.
    assign req_ready = ((state == IDLE) && rst) ? grant : '0;

    // cnt tracks cycles since the ld cycle (ld cycle = 0), so the abort lands TIMEOUT cycles after ld.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            aes_ld      <= 1'b0;
            aes_key     <= '0;
            aes_text_in <= '0;
            resp_valid  <= 1'b0;
            resp_text   <= '0;
            resp_id     <= '0;
            resp_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        aes_key     <= sel_key;
                        aes_text_in <= sel_text;
                        resp_id     <= win_idx;
                        rr_ptr      <= (win_idx == ID_LAST) ? '0 : win_idx + 1'b1;
                        cnt         <= '0;
                        aes_ld      <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    aes_ld <= 1'b0;
                    cnt    <= cnt + 1'b1;
                    state  <= BUSY;
                end
                BUSY: begin
                    if (aes_done) begin
                        resp_text  <= aes_text_out;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        resp_text  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_sched.sv
// Directed bench for aes_cipher_sched with a behavioural cipher-core stub.
module tb_aes_cipher_sched;
    import aes_sched_pkg::*;

    localparam int NREQ = 2;
    localparam int TO   = 32;

    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KA = {4{32'hA5A5_0000}};
    localparam logic [127:0] TA = {4{32'h0000_5A5A}};
    localparam logic [127:0] XA = {4{32'hA5A5_5A5A}};
    localparam logic [127:0] KB = {4{32'h1234_5678}};
    localparam logic [127:0] TB = {4{32'h8765_4321}};
    localparam logic [127:0] XB = {4{32'h9551_1559}};
    localparam logic [127:0] KC = 128'h0123456789abcdef_0123456789abcdef;
    localparam logic [127:0] TC = 128'hffffffffffffffff_0000000000000000;
    localparam logic [127:0] XC = 128'hfedcba9876543210_0123456789abcdef;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*128-1:0] req_key;
    logic [NREQ*128-1:0] req_text;
    logic              resp_valid;
    logic              resp_ready;
    logic [127:0]      resp_text;
    logic [0:0]        resp_id;
    logic              resp_err;
    logic              aes_ld;
    logic [127:0]      aes_key;
    logic [127:0]      aes_text_in;
    logic              aes_done;
    logic [127:0]      aes_text_out;
    logic              busy;
    sched_state_t      state;

    int checks;
    int errors;

    aes_cipher_sched #(
        .NUM_REQ (NREQ),
        .ID_W    (1),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_key      (req_key),
        .req_text     (req_text),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_text    (resp_text),
        .resp_id      (resp_id),
        .resp_err     (resp_err),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out),
        .busy         (busy),
        .state        (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- core stub ----------------
    int           stub_lat;
    int           stub_cur_lat;
    int           stub_k;
    bit           stub_armed;
    logic [127:0] stub_key;
    logic [127:0] stub_text;
    int           ld_count;
    int           spur_cnt;
    int           spur_seen;
    logic [127:0] spur_text;

    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
        if (k == FK && t == FP) return FC;
        return k ^ t;
    endfunction

    // Done is driven at the negedge of cycle ld+lat so the DUT samples it on that cycle's closing edge.
    always @(negedge clk) begin
        aes_done = 1'b0;
        if (!rst) begin
            stub_armed = 1'b0;
        end else begin
            if (stub_armed) begin
                stub_k++;
                if (stub_k == stub_cur_lat) begin
                    aes_done     = 1'b1;
                    aes_text_out = core_fn(stub_key, stub_text);
                    stub_armed   = 1'b0;
                end
            end
            if (spur_cnt != spur_seen) begin
                aes_done     = 1'b1;
                aes_text_out = spur_text;
                spur_seen    = spur_cnt;
            end
            if (aes_ld) begin
                ld_count++;
                stub_key     = aes_key;
                stub_text    = aes_text_in;
                stub_k       = 0;
                stub_cur_lat = stub_lat;
                stub_armed   = (stub_lat > 0);
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]   valid;
        logic [127:0] key0;
        logic [127:0] text0;
        logic [127:0] key1;
        logic [127:0] text1;
        int           lat;
        int           bp;
        logic [1:0]   exp_grant;
        logic         exp_id;
        logic         exp_err;
        logic [127:0] exp_text;
        int           exp_lat;
    } vec_t;

    vec_t vecs[10];
    vec_t vec_after_rst;

    function automatic vec_t mk(input logic [1:0] valid, input logic [127:0] k0, input logic [127:0] t0,
                                input logic [127:0] k1, input logic [127:0] t1, input int lat, input int bp,
                                input logic [1:0] g, input logic id, input logic err,
                                input logic [127:0] et, input int el);
        vec_t v;
        v.valid = valid; v.key0 = k0; v.text0 = t0; v.key1 = k1; v.text1 = t1;
        v.lat = lat; v.bp = bp; v.exp_grant = g; v.exp_id = id; v.exp_err = err;
        v.exp_text = et; v.exp_lat = el;
        return v;
    endfunction

    // ---------------- driver ----------------
    // Entered and left 1 ns after a negedge, with the DUT in IDLE.
    task automatic run_job(input vec_t v);
        logic [127:0] wkey;
        logic [127:0] wtext;
        logic [127:0] snap_text;
        int           n;
        int           k;
        int           ld0;
        bit           stable_ok;
        wkey       = v.exp_id ? v.key1 : v.key0;
        wtext      = v.exp_id ? v.text1 : v.text0;
        req_valid  = v.valid;
        req_key    = {v.key1, v.key0};
        req_text   = {v.text1, v.text0};
        stub_lat   = v.lat;
        resp_ready = (v.bp == 0);
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chki("accept_wait", int'(n < 50), 1);
        chki("grant", int'(req_ready), int'(v.exp_grant));
        ld0 = ld_count;
        @(negedge clk); #1;
        chki("ld_pulse", int'(aes_ld), 1);
        chki("ready_in_load", int'(req_ready), 0);
        chki("busy_in_load", int'(busy), 1);
        chk128("load_key", aes_key, wkey);
        chk128("load_text", aes_text_in, wtext);
        k = 0;
        while (!resp_valid && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        chki("resp_latency", k, v.exp_lat);
        chki("ld_count", ld_count - ld0, 1);
        chk128("resp_text", resp_text, v.exp_text);
        chki("resp_id", int'(resp_id), int'(v.exp_id));
        chki("resp_err", int'(resp_err), int'(v.exp_err));
        chk128("key_held_resp", aes_key, wkey);
        if (v.bp > 0) begin
            stable_ok = 1'b1;
            snap_text = v.exp_text;
            repeat (v.bp) begin
                @(negedge clk); #1;
                if (resp_valid !== 1'b1 || resp_text !== snap_text || resp_id !== v.exp_id ||
                    resp_err !== v.exp_err || req_ready !== '0 || state !== RESP)
                    stable_ok = 1'b0;
            end
            chki("bp_hold", int'(stable_ok), 1);
            resp_ready = 1'b1;
        end
        @(negedge clk); #1;
        chki("resp_drop", int'(resp_valid), 0);
        chki("idle_busy", int'(busy), 0);
        chki("idle_state", int'(state), int'(IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bit quiet;
        checks = 0; errors = 0;
        rst = 1'b0; req_valid = '0; req_key = '0; req_text = '0; resp_ready = 1'b0;
        aes_done = 1'b0; aes_text_out = '0; stub_lat = 12; stub_cur_lat = 0; stub_k = 0;
        stub_armed = 1'b0; stub_key = '0; stub_text = '0; ld_count = 0;
        spur_cnt = 0; spur_seen = 0; spur_text = '0;

        vecs[0] = mk(2'b11, KA, TA, KB, TB, 12, 0, 2'b01, 1'b0, 1'b0, XA, 13);
        vecs[1] = mk(2'b11, KA, TA, KB, TB, 12, 0, 2'b10, 1'b1, 1'b0, XB, 13);
        vecs[2] = mk(2'b11, KA, TA, KB, TB, 12, 0, 2'b01, 1'b0, 1'b0, XA, 13);
        vecs[3] = mk(2'b11, KA, TA, KB, TB, 12, 0, 2'b10, 1'b1, 1'b0, XB, 13);
        vecs[4] = mk(2'b01, FK, FP, KB, TB, 12, 0, 2'b01, 1'b0, 1'b0, FC, 13);
        vecs[5] = mk(2'b01, KC, TC, KB, TB, 12, 20, 2'b01, 1'b0, 1'b0, XC, 13);
        vecs[6] = mk(2'b10, KA, TA, KB, TB, 0, 0, 2'b10, 1'b1, 1'b1, 128'h0, TO);
        vecs[7] = mk(2'b01, KC, TC, KB, TB, TO - 1, 0, 2'b01, 1'b0, 1'b0, XC, TO);
        vecs[8] = mk(2'b01, KA, TA, KB, TB, 12, 0, 2'b01, 1'b0, 1'b0, XA, 13);
        vecs[9] = mk(2'b11, KA, TA, KB, TB, 12, 0, 2'b10, 1'b1, 1'b0, XB, 13);
        vec_after_rst = mk(2'b11, KB, TB, KA, TA, 12, 0, 2'b01, 1'b0, 1'b0, XB, 13);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chki("rst_state", int'(state), int'(IDLE));
        chki("rst_resp_valid", int'(resp_valid), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_aes_ld", int'(aes_ld), 0);
        chk128("rst_aes_key", aes_key, 128'h0);
        rst = 1'b1;

        // Table: contention, FIPS-197, backpressure, timeout, done at TIMEOUT-1, rotation skip
        foreach (vecs[i]) run_job(vecs[i]);
        req_valid = '0;

        // Spurious done while IDLE
        spur_text = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        spur_cnt++;
        repeat (3) begin @(negedge clk); #1; end
        chki("spur_idle_state", int'(state), int'(IDLE));
        chki("spur_idle_valid", int'(resp_valid), 0);
        chki("spur_idle_busy", int'(busy), 0);
        chk128("spur_idle_text", resp_text, vecs[9].exp_text);

        // Spurious done while RESP is held by backpressure
        req_valid = 2'b01; req_key = {KB, KC}; req_text = {TB, TC}; stub_lat = 12; resp_ready = 1'b0;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin @(negedge clk); #1; n++; end
        chki("spur_resp_grant", int'(req_ready), 1);
        @(negedge clk); #1;
        req_valid = '0;
        n = 0;
        while (!resp_valid && n < 100) begin @(negedge clk); #1; n++; end
        chki("spur_resp_reached", int'(resp_valid), 1);
        spur_cnt++;
        repeat (3) begin @(negedge clk); #1; end
        chki("spur_resp_state", int'(state), int'(RESP));
        chk128("spur_resp_text", resp_text, XC);
        chki("spur_resp_err", int'(resp_err), 0);
        resp_ready = 1'b1;
        @(negedge clk); #1;
        chki("spur_resp_done", int'(resp_valid), 0);

        // Reset mid-job: req0 is served (pointer moves to 1), then reset 5 cycles after ld
        req_valid = 2'b01; req_key = {KB, KA}; req_text = {TB, TA}; stub_lat = 0;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin @(negedge clk); #1; n++; end
        chki("mid_grant", int'(req_ready), 1);
        @(negedge clk); #1;
        chki("mid_ld", int'(aes_ld), 1);
        req_valid = '0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chki("mid_state", int'(state), int'(IDLE));
        chki("mid_busy", int'(busy), 0);
        chki("mid_resp_valid", int'(resp_valid), 0);
        chki("mid_req_ready", int'(req_ready), 0);
        chk128("mid_aes_key", aes_key, 128'h0);
        chk128("mid_aes_text", aes_text_in, 128'h0);
        chk128("mid_resp_text", resp_text, 128'h0);
        chki("mid_resp_err", int'(resp_err), 0);
        @(negedge clk); #1;
        chki("mid_no_resp", int'(resp_valid), 0);
        rst = 1'b1;
        run_job(vec_after_rst);
        req_valid = '0;

        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            if (resp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        chki("final_quiet", int'(quiet), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_cipher_sched.md
Name: aes_cipher_sched

Overview:
Round-robin scheduler that shares one aes_cipher_top instance between NUM_REQ requesters. It accepts {key, plaintext} jobs over valid/ready handshakes and issues the one-cycle ld pulse to the core. It captures text_out on the core's done pulse and returns the ciphertext with the requester ID over a single valid/ready response channel. Sits between the bus-side request ports and the cipher core; exactly one job is in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, requester-ID width, equal to $clog2(NUM_REQ) with a minimum of 1
TIMEOUT, 32, max cycles from ld to done before the job is aborted (must be > 12)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  job offered, one bit per requester
req_ready  out  NUM_REQ  job accepted this cycle (one-hot or zero)
req_key  in  NUM_REQ*128  per-requester key; slice i = [128*i +: 128]
req_text  in  NUM_REQ*128  per-requester plaintext
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_text  out  128  ciphertext (zero on error)
resp_id  out  ID_W  requester index of the result
resp_err  out  1  job timed out
aes_ld  out  1  load strobe to core
aes_key  out  128  key to core
aes_text_in  out  128  plaintext to core
aes_done  in  1  core completion pulse, one cycle
aes_text_out  in  128  core ciphertext, valid when aes_done=1
busy  out  1  job in flight or result pending

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, all outputs 0, and the key, text, result and ID registers are cleared.
- FSM states:
  - IDLE: rotate-priority select among req_valid, starting at rr_ptr. If any request is valid, assert req_ready only for the winner (combinational, same cycle). On the handshake, register key, text and ID, set rr_ptr=winner+1 mod NUM_REQ, and go to LOAD. If no request is valid, req_ready=0.
  - LOAD: aes_ld=1 for exactly one cycle, cnt=0, then go to BUSY.
  - BUSY: cnt increments each cycle.
    - aes_done=1: capture aes_text_out, resp_err=0, go to RESP.
    - Otherwise, when cnt==TIMEOUT-1: resp_text=0, resp_err=1, go to RESP.
    - aes_done and timeout in the same cycle: done wins.
  - RESP: resp_valid=1. resp_text, resp_id and resp_err are held stable until resp_ready=1, then go to IDLE. A request cannot be accepted in the same cycle as the response handshake.
- aes_key and aes_text_in are driven from registers and are stable from LOAD through RESP.
- aes_done outside BUSY is ignored.
- req_ready is 0 in every state except IDLE.
- busy=1 whenever state != IDLE.
- Minimum job period: 1 accept + 1 LOAD + core latency (~12) + 1 RESP.
- Fairness: a requester that holds valid is served within NUM_REQ jobs.
- Reset mid-job returns to IDLE immediately. The in-flight job is dropped and no response is issued.
- Pointer wrap: NUM_REQ-1 -> 0.

Decomposition:
- Package aes_sched_pkg: state enum typedef (IDLE, LOAD, BUSY, RESP) and the TIMEOUT default constant.
- Sub-module rr_arbiter (NUM_REQ): combinational rotate-priority grant from req and ptr, producing a one-hot grant plus an index.
- aes_cipher_top is instantiated by the parent, not inside this block.

Test Plan:
1. FIPS-197: req0 with key 000102030405060708090a0b0c0d0e0f and text 00112233445566778899aabbccddeeff, resp_ready=1.
   -> One aes_ld pulse the cycle after accept; resp_text=69c4e0d86a7b0430d8cdb78070b4c55a, resp_id=0, resp_err=0.
2. Contention: req0 and req1 both hold valid for 4 jobs.
   -> Grant order 0,1,0,1; each resp_id matches its grant; no second ld while busy=1.
3. Backpressure: resp_ready=0 for 20 cycles after resp_valid rises.
   -> resp_text, resp_id and resp_err stay stable; req_ready stays 0; the job completes on the first resp_ready=1.
4. Timeout: core stub never asserts done.
   -> resp_valid rises TIMEOUT cycles after ld with resp_err=1 and resp_text=0. A separate stub asserts done on exactly cycle TIMEOUT-1 -> resp_err=0.
5. Reset mid-job: rst=0 asynchronously 5 cycles after ld.
   -> All outputs 0 with no clock edge; after release, state IDLE, no resp_valid, next grant goes to req0.
6. Spurious done: pulse aes_done while in IDLE and while in RESP.
   -> Ignored; no state change and the held resp_text is unchanged.
